act_skew_feeder: RTL
====================

# act_skew_feeder

Upstream feeder for the systolic PE array: accepts whole activation vectors (one element per array row) over a valid/ready handshake, buffers them in a small FIFO, and issues them diagonally skewed so row r receives its element r cycles after row 0. Its per-row outputs drive the `ain` inputs of the left-column PEs directly. It tracks tile boundaries, drains the skew pipeline after the last vector of a tile, and signals completion to the controller.

## Interface
- `ROWS`, 4, number of array rows/lanes; must be ≥ 2
- `DATA_W`, 8, activation width; matches PE `ain`
- `DEPTH`, 8, FIFO depth in vectors; power of two, ≥ 2
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream vector valid
- `in_ready`  out  1  FIFO can accept; equals !full; 0 while reset_n low
- `in_data`  in  ROWS*DATA_W  vector; lane r = bits [r*DATA_W +: DATA_W]
- `in_last`  in  1  marks last vector of a tile; stored with the vector
- `issue_en`  in  1  controller permission to pop/issue
- `a_out`  out  ROWS*DATA_W  skewed lane data to PE `ain`
- `a_valid`  out  ROWS  per-lane valid
- `tile_done`  out  1  one-cycle pulse, last element of tile on lane ROWS-1
- `fifo_count`  out  $clog2(DEPTH+1)  occupancy
- `busy`  out  1  FIFO non-empty, any a_valid high, or state ≠ IDLE

## Operation
- Push: `in_valid && in_ready` writes {in_last, in_data}. No push when full.
- Pop: `issue_en && !empty && state != DRAIN`. At most one pop/cycle.
- Push and pop in the same cycle: count unchanged. Push into empty FIFO is not poppable until the next cycle (no fall-through).
- Skew lanes: lane r is an r-stage shift register on {valid, data} fed from the pop-cycle output; lanes shift every cycle unconditionally. A non-pop cycle injects a bubble (valid 0) that travels the same diagonal.
- FSM: IDLE → STREAM on first pop. STREAM stays while popping non-last vectors; idle cycles (issue_en low or empty) stay in STREAM. Popping an in_last vector → DRAIN with counter = ROWS-1. DRAIN: no pops; counter decrements; at 0 → IDLE and `tile_done` pulses in that cycle.
- `tile_done` is registered; asserted in the same cycle lane ROWS-1 presents the tile's last element.
- Reset (any time, including mid-tile): FIFO empty, all lanes invalid, `a_out`=0, `tile_done`=0, `fifo_count`=0, `busy`=0, state IDLE. In-flight data is discarded.
- No arithmetic besides pointer/counter increments; pointers wrap modulo DEPTH; count saturates only by construction (push blocked when full).

## Timing
- Vector accepted at cycle c into an empty FIFO with issue_en high: popped at c+1, lane 0 valid at c+2, lane r valid at c+2+r.
- Last vector popped at t: DRAIN occupies t+1..t+ROWS-1; `tile_done` and lane ROWS-1 last element at t+ROWS; next pop allowed at t+ROWS.
- `in_ready` depends only on registered count; no combinational path from `issue_en` or `in_valid`.
- Sustained throughput: one vector/cycle within a tile; ROWS-1 bubble cycles between tiles.

## Configuration
- `ACT_SKEW_ZERO_GATE_EN` defined: `a_out` lane r forced to 0 whenever `a_valid[r]`=0, so PEs without valid inputs accumulate zero on bubbles.
- Undefined: lane data registers load only on valid; `a_out` holds its last valid value; consumers must qualify with `a_valid`. Reset value of `a_out` is 0 in both builds.

## Structure
- Shared package `tpu_pkg`: `DATA_W` default, FSM state enum {IDLE, STREAM, DRAIN}.
- One sub-module: `skew_fifo` (sync FIFO, width ROWS*DATA_W+1, depth DEPTH, count output). Skew lanes and FSM stay in the top module.

## Test plan
- Reset, ROWS=4: push vector {4,3,2,1} last=1 at c, issue_en=1 -> lane0=1 at c+2, lane1=2 at c+3, lane2=3 at c+4, lane3=4 at c+5 with `tile_done` at c+5.
- Fill 8 vectors, issue_en=0 -> `in_ready`=0, `fifo_count`=8; 9th in_valid not accepted; pop one -> in_ready 1 next cycle.
- Tile of 3 vectors with issue_en low for one cycle mid-tile -> one bubble appears diagonally (lane r at bubble cycle+r), data order intact; zero-gate build shows `a_out`=0 on bubble.
- Two back-to-back tiles queued -> exactly ROWS-1 cycles with no pop between tiles; one `tile_done` per tile.
- Simultaneous push and pop at count 3 -> count stays 3.
- reset_n low during DRAIN -> next cycle all `a_valid`=0, `tile_done` never fires, `fifo_count`=0, `busy`=0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the systolic array front end: default activation width and feeder FSM states.
// No logic; compile-time only.
// Not applicable (no handshakes).
package tpu_pkg;

   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feed_state_t;

endpackage

// File: rtl/act_skew_feeder_if.sv
// Vector-in / skewed-lanes-out bundle between the upstream source, the controller and the feeder.
// Wires only; no latency.
// in_valid/in_ready handshake upstream, issue_en permission from the controller.
interface act_skew_feeder_if
   import tpu_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 8
);

   logic                         in_valid;
   logic                         in_ready;
   logic [ROWS*DATA_W-1:0]       in_data;
   logic                         in_last;
   logic                         issue_en;
   logic [ROWS*DATA_W-1:0]       a_out;
   logic [ROWS-1:0]              a_valid;
   logic                         tile_done;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count;
   logic                         busy;

   // source + controller side
   modport master (
      output in_valid, in_data, in_last, issue_en,
      input  in_ready, a_out, a_valid, tile_done, fifo_count, busy
   );

   // feeder side
   modport slave (
      input  in_valid, in_data, in_last, issue_en,
      output in_ready, a_out, a_valid, tile_done, fifo_count, busy
   );

endinterface

// File: rtl/skew_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head entry, shown combinationally.
// Write visible for read one cycle after the push (no fall-through).
// Writes ignored when full, reads ignored when empty.
module skew_fifo
   import tpu_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // pointers wrap naturally since DEPTH is a power of two; count tracks push minus pop
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage array is not reset; stale entries are never readable because count gates reads
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and issues them diagonally skewed (lane r delayed r cycles) to the PE array.
// Latency: accept at c -> pop at c+1 -> lane r valid at c+2+r; ROWS-1 drain cycles after each tile.
// in_ready = !full (registered count only); pops gated by issue_en. Build option: ACT_SKEW_ZERO_GATE_EN.
module act_skew_feeder
   import tpu_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   act_skew_feeder_if.slave bus
);

   localparam int VW  = ROWS*DATA_W;
   localparam int CW  = $clog2(DEPTH+1);
   localparam int DCW = $clog2(ROWS);

   logic [VW:0]           rd_data;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic                  pop;
   logic                  pop_last;
   feed_state_t           state;
   logic [DCW-1:0]        drain_cnt;
   logic                  tile_done_q;
   logic [ROWS-1:0]       a_valid_w;
   logic [VW-1:0]         a_out_w;

   assign bus.in_ready   = reset_n && !full;
   assign pop            = bus.issue_en && !empty && (state != DRAIN);
   assign pop_last       = rd_data[VW];
   assign bus.fifo_count = count;
   assign bus.tile_done  = tile_done_q;
   assign bus.a_valid    = a_valid_w;
   assign bus.a_out      = a_out_w;
   assign bus.busy       = !empty || (|a_valid_w) || (state != IDLE);

   skew_fifo #(
      .WIDTH (VW+1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (bus.in_valid && bus.in_ready),
      .wr_data ({bus.in_last, bus.in_data}),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // tile tracking: popping a last vector blocks pops for ROWS-1 cycles, then pulses tile_done
   // exactly when lane ROWS-1 shows that vector's element
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         tile_done_q <= 1'b0;
      end else begin
         tile_done_q <= 1'b0;
         case (state)
            IDLE, STREAM: begin
               if (pop) begin
                  if (pop_last) begin
                     state     <= DRAIN;
                     drain_cnt <= DCW'(ROWS-1);
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - 1'b1;
               if (drain_cnt == DCW'(1)) begin
                  state       <= IDLE;
                  tile_done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [r:0]        vld_q;
      logic [DATA_W-1:0] dat_q [r+1];

      // r+1 stage shift per lane, advancing every cycle; data stages load only behind a valid
      // so the tail holds the most recent element across bubbles
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k <= r; k++) dat_q[k] <= '0;
         end else begin
            vld_q[0] <= pop;
            if (pop) dat_q[0] <= rd_data[r*DATA_W +: DATA_W];
            for (int k = 1; k <= r; k++) begin
               vld_q[k] <= vld_q[k-1];
               if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
         end
      end

      assign a_valid_w[r] = vld_q[r];
`ifdef ACT_SKEW_ZERO_GATE_EN
      assign a_out_w[r*DATA_W +: DATA_W] = vld_q[r] ? dat_q[r] : '0;
`else
      assign a_out_w[r*DATA_W +: DATA_W] = dat_q[r];
`endif
   end

endmodule
